// File: rtl/param_timestamp_timer.sv
// Free-running timestamp counter with programmable prescaler, atomic multi-word
// snapshot, NUM_CMP compare channels with sticky flags and a maskable level IRQ.
module param_timestamp_timer #(
  parameter int COUNTER_WIDTH  = 64,
  parameter int NUM_CMP        = 2,
  parameter int PRESCALE_WIDTH = 16,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [ADDR_WIDTH-1:0]    timestamp_timer_address,
  input  logic [15:0]              timestamp_timer_writedata,
  output logic [15:0]              timestamp_timer_readdata,
  input  logic                     timestamp_timer_chipselect,
  input  logic                     timestamp_timer_write_n,
  input  logic                     snap_trig,
  output logic                     irq,
  output logic [COUNTER_WIDTH-1:0] count_value
);

  localparam int NUM_WORDS = COUNTER_WIDTH / 16;

  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_CONTROL  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_SNAPCMD  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_SNAP_LO  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_SNAP_HI  = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] A_CMPSEL   = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_CMP_LO   = ADDR_WIDTH'(12);
  localparam logic [ADDR_WIDTH-1:0] A_CMP_HI   = ADDR_WIDTH'(15);

  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [COUNTER_WIDTH-1:0]  snap_q, snap_d;
  logic [COUNTER_WIDTH-1:0]  shadow_q, shadow_d;
  logic [COUNTER_WIDTH-1:0]  cmp_q [NUM_CMP];
  logic [COUNTER_WIDTH-1:0]  cmp_d [NUM_CMP];
  logic [15:0]               cmp_sel_q, cmp_sel_d;
  logic                      run_q, run_d;
  logic                      ovf_ie_q, ovf_ie_d;
  logic [NUM_CMP-1:0]        match_ie_q, match_ie_d;
  logic                      ovf_q, ovf_d;
  logic [NUM_CMP-1:0]        match_q, match_d;
  logic [15:0]               rdata_q, rdata_d;
  logic                      irq_q, irq_d;

  logic                      wr_en;
  logic                      status_wr, ctrl_wr, pre_wr, snap_wr, sel_wr, cmp_wr;
  logic                      is_snap_addr, is_cmp_addr;
  logic [1:0]                word_idx;
  logic                      clear;
  logic                      tick;
  logic                      count_live;
  logic [COUNTER_WIDTH-1:0]  cnt_inc;
  logic                      ovf_set;
  logic [NUM_CMP-1:0]        match_set;
  logic [COUNTER_WIDTH-1:0]  cmp_new;
  logic [COUNTER_WIDTH-1:0]  cmp_cur;

  // Address decode and strobes
  always_comb begin
    wr_en        = timestamp_timer_chipselect && !timestamp_timer_write_n;
    word_idx     = timestamp_timer_address[1:0];
    is_snap_addr = (timestamp_timer_address >= A_SNAP_LO) &&
                   (timestamp_timer_address <= A_SNAP_HI);
    is_cmp_addr  = (timestamp_timer_address >= A_CMP_LO) &&
                   (timestamp_timer_address <= A_CMP_HI);
    status_wr    = wr_en && (timestamp_timer_address == A_STATUS);
    ctrl_wr      = wr_en && (timestamp_timer_address == A_CONTROL);
    pre_wr       = wr_en && (timestamp_timer_address == A_PRESCALE);
    snap_wr      = wr_en && (timestamp_timer_address == A_SNAPCMD);
    sel_wr       = wr_en && (timestamp_timer_address == A_CMPSEL);
    cmp_wr       = wr_en && is_cmp_addr;
  end

  // Tick generation and counter events; CLEAR suppresses any event from a coincident tick
  always_comb begin
    clear      = ctrl_wr && timestamp_timer_writedata[1];
    tick       = run_q && (pre_q == prescale_q);
    count_live = tick && !clear;
    cnt_inc    = cnt_q + COUNTER_WIDTH'(1);
    ovf_set    = count_live && (cnt_q == {COUNTER_WIDTH{1'b1}});
    match_set  = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      match_set[i] = count_live && (cnt_inc == cmp_q[i]);
    end
  end

  always_comb begin
    pre_d = pre_q;
    if (clear || pre_wr || tick) begin
      pre_d = '0;
    end else if (run_q) begin
      pre_d = pre_q + PRESCALE_WIDTH'(1);
    end

    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_inc;
    end
  end

  // Control, prescale, select and snapshot registers
  always_comb begin
    run_d      = run_q;
    ovf_ie_d   = ovf_ie_q;
    match_ie_d = match_ie_q;
    if (ctrl_wr) begin
      run_d      = timestamp_timer_writedata[0];
      ovf_ie_d   = timestamp_timer_writedata[8];
      match_ie_d = timestamp_timer_writedata[8+NUM_CMP:9];
    end

    prescale_d = prescale_q;
    if (pre_wr) begin
      prescale_d = timestamp_timer_writedata[PRESCALE_WIDTH-1:0];
    end

    cmp_sel_d = cmp_sel_q;
    if (sel_wr) begin
      cmp_sel_d = timestamp_timer_writedata;
    end

    snap_d = snap_q;
    if (snap_wr || snap_trig) begin
      snap_d = cnt_q;
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-clear keeps the flag
  always_comb begin
    ovf_d = ovf_set || (ovf_q && !(status_wr && timestamp_timer_writedata[0]));
    match_d = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      match_d[i] = match_set[i] ||
                   (match_q[i] && !(status_wr && timestamp_timer_writedata[i+1]));
    end
    irq_d = (ovf_q && ovf_ie_q) || (|(match_q & match_ie_q));
  end

  // Compare shadow and atomic commit on word0
  always_comb begin
    shadow_d = shadow_q;
    if (cmp_wr) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (word_idx == 2'(k)) begin
          shadow_d[16*k +: 16] = timestamp_timer_writedata;
        end
      end
    end

    cmp_new        = shadow_q;
    cmp_new[15:0]  = timestamp_timer_writedata;

    for (int i = 0; i < NUM_CMP; i++) begin
      cmp_d[i] = cmp_q[i];
      if (cmp_wr && (word_idx == 2'd0) && (cmp_sel_q == 16'(i))) begin
        cmp_d[i] = cmp_new;
      end
    end

    cmp_cur = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (cmp_sel_q == 16'(i)) begin
        cmp_cur = cmp_q[i];
      end
    end
  end

  // Read mux; anything unmapped reads zero
  always_comb begin
    rdata_d = '0;
    case (timestamp_timer_address)
      A_STATUS: begin
        rdata_d[0]         = ovf_q;
        rdata_d[NUM_CMP:1] = match_q;
        rdata_d[15]        = run_q;
      end
      A_CONTROL: begin
        rdata_d[0]             = run_q;
        rdata_d[8]             = ovf_ie_q;
        rdata_d[8+NUM_CMP:9]   = match_ie_q;
      end
      A_PRESCALE: rdata_d = 16'(prescale_q);
      A_CMPSEL:   rdata_d = cmp_sel_q;
      default: begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (word_idx == 2'(k)) begin
            if (is_snap_addr) begin
              rdata_d = snap_q[16*k +: 16];
            end else if (is_cmp_addr) begin
              rdata_d = cmp_cur[16*k +: 16];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q      <= '0;
      pre_q      <= '0;
      prescale_q <= '0;
      snap_q     <= '0;
      shadow_q   <= '1;
      cmp_q      <= '{default: '1};
      cmp_sel_q  <= '0;
      run_q      <= 1'b0;
      ovf_ie_q   <= 1'b0;
      match_ie_q <= '0;
      ovf_q      <= 1'b0;
      match_q    <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      snap_q     <= snap_d;
      shadow_q   <= shadow_d;
      cmp_q      <= cmp_d;
      cmp_sel_q  <= cmp_sel_d;
      run_q      <= run_d;
      ovf_ie_q   <= ovf_ie_d;
      match_ie_q <= match_ie_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign timestamp_timer_readdata = rdata_q;
  assign irq                      = irq_q;
  assign count_value              = cnt_q;

endmodule

// File: tb/tb_param_timestamp_timer.sv
// Directed test of param_timestamp_timer: a 64-bit instance for most checks and a
// 16-bit instance for the wrap/overflow path; register reads go through a scoreboard.
module tb_param_timestamp_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic        wn;
  logic        cs_a, cs_b;
  logic        trig_a, trig_b;
  logic [15:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;
  logic [63:0] cnt_a;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  param_timestamp_timer #(.COUNTER_WIDTH(64), .NUM_CMP(2), .PRESCALE_WIDTH(16), .ADDR_WIDTH(4)) u_dut (
    .clk_clk                    (clk),
    .reset_reset_n              (rst_n),
    .timestamp_timer_address    (addr),
    .timestamp_timer_writedata  (wdata),
    .timestamp_timer_readdata   (rdata_a),
    .timestamp_timer_chipselect (cs_a),
    .timestamp_timer_write_n    (wn),
    .snap_trig                  (trig_a),
    .irq                        (irq_a),
    .count_value                (cnt_a)
  );

  param_timestamp_timer #(.COUNTER_WIDTH(16), .NUM_CMP(2), .PRESCALE_WIDTH(16), .ADDR_WIDTH(4)) u_dut16 (
    .clk_clk                    (clk),
    .reset_reset_n              (rst_n),
    .timestamp_timer_address    (addr),
    .timestamp_timer_writedata  (wdata),
    .timestamp_timer_readdata   (rdata_b),
    .timestamp_timer_chipselect (cs_b),
    .timestamp_timer_write_n    (wn),
    .snap_trig                  (trig_b),
    .irq                        (irq_b),
    .count_value                (cnt_b)
  );

  typedef struct {
    logic [15:0] exp;
    bit          sel_b;
    string       name;
  } sb_t;

  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic rd_issue = 1'b0;
  logic rd_v = 1'b0;

  // Read data appears one edge after the read is presented
  always @(posedge clk) rd_v <= rd_issue;

  always @(negedge clk) begin
    sb_t         it;
    logic [15:0] act;
    if (rd_v) begin
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: read data with no expected entry");
      end else begin
        it  = sb_q.pop_front();
        act = it.sel_b ? rdata_b : rdata_a;
        n_vec++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: readdata=%h expected=%h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wr(input bit b, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; wn = 1'b0;
    if (b) cs_b = 1'b1; else cs_a = 1'b1;
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0; wn = 1'b1;
  endtask

  task automatic rd(input bit b, input logic [3:0] a, input logic [15:0] e, input string name);
    sb_t it;
    @(negedge clk);
    addr = a; wn = 1'b1;
    if (b) cs_b = 1'b1; else cs_a = 1'b1;
    it.exp = e; it.sel_b = b; it.name = name;
    sb_q.push_back(it);
    rd_issue = 1'b1;
    @(posedge clk); #1;
    rd_issue = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap_exp;
    logic [63:0] prev;
    logic [63:0] base;
    bit          found;

    rst_n = 1'b0; addr = '0; wdata = '0; wn = 1'b1;
    cs_a = 1'b0; cs_b = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_cnt", cnt_a, 64'h0);
    check("rst_irq", {63'h0, irq_a}, 64'h0);
    for (int a = 0; a < 16; a++) begin
      rd(1'b0, 4'(a), (a >= 12) ? 16'hFFFF : 16'h0000, "rst_read");
    end
    rd(1'b1, 4'd12, 16'hFFFF, "rst16_cmp_w0");
    rd(1'b1, 4'd13, 16'h0000, "rst16_cmp_w1_absent");

    // Prescale 3: one count every 4 cycles
    wr(1'b0, 4'd2, 16'd3);
    wr(1'b0, 4'd1, 16'h0001);
    repeat (40) @(negedge clk);
    @(negedge clk);
    snap_exp = cnt_a;
    check("cnt_at_snap", cnt_a, 64'd10);
    addr = 4'd3; wdata = 16'h0; wn = 1'b0; cs_a = 1'b1;
    @(posedge clk); #1;
    cs_a = 1'b0; wn = 1'b1;
    rd(1'b0, 4'd4, snap_exp[15:0],  "snap_w0");
    rd(1'b0, 4'd5, snap_exp[31:16], "snap_w1");
    rd(1'b0, 4'd6, snap_exp[47:32], "snap_w2");
    rd(1'b0, 4'd7, snap_exp[63:48], "snap_w3");
    rd(1'b0, 4'd2, 16'd3, "prescale_rb");

    prev  = cnt_a;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cnt_a != prev) begin found = 1'b1; break; end
    end
    check("step_seen", {63'h0, found}, 64'h1);
    base = cnt_a;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check("prescale_hold", cnt_a, base);
    end
    @(negedge clk);
    check("prescale_step", cnt_a, base + 64'd1);

    // Compare channel 1 at 0x20, prescale 0
    wr(1'b0, 4'd1, 16'h0002);
    wr(1'b0, 4'd2, 16'h0000);
    wr(1'b0, 4'd8, 16'h0001);
    wr(1'b0, 4'd13, 16'h0000);
    rd(1'b0, 4'd13, 16'hFFFF, "cmp_shadow_only");
    rd(1'b0, 4'd12, 16'hFFFF, "cmp_before_commit");
    wr(1'b0, 4'd15, 16'h0000);
    wr(1'b0, 4'd14, 16'h0000);
    wr(1'b0, 4'd12, 16'h0020);
    rd(1'b0, 4'd12, 16'h0020, "cmp1_w0");
    rd(1'b0, 4'd13, 16'h0000, "cmp1_w1");
    rd(1'b0, 4'd15, 16'h0000, "cmp1_w3");
    rd(1'b0, 4'd0, 16'h0000, "status_stopped");
    rd(1'b0, 4'd8, 16'h0001, "cmp_sel_rb");
    wr(1'b0, 4'd1, 16'h0401);
    rd(1'b0, 4'd1, 16'h0401, "control_rb");
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cnt_a == 64'h20) begin found = 1'b1; break; end
    end
    check("match_reach", {63'h0, found}, 64'h1);
    check("irq_same_cycle", {63'h0, irq_a}, 64'h0);
    @(negedge clk);
    check("irq_next_cycle", {63'h0, irq_a}, 64'h1);
    rd(1'b0, 4'd0, 16'h8004, "status_match1");

    // Out-of-range select: commit dropped, reads zero
    wr(1'b0, 4'd8, 16'h0002);
    rd(1'b0, 4'd12, 16'h0000, "cmp_sel_oor_rd");
    wr(1'b0, 4'd12, 16'h1234);
    wr(1'b0, 4'd8, 16'h0000);
    rd(1'b0, 4'd12, 16'hFFFF, "cmp0_untouched_w0");
    rd(1'b0, 4'd13, 16'hFFFF, "cmp0_untouched_w1");
    wr(1'b0, 4'd8, 16'h0001);
    rd(1'b0, 4'd12, 16'h0020, "cmp1_kept");

    // Write-1-clear, then clear colliding with a fresh match
    wr(1'b0, 4'd1, 16'h0402);
    wr(1'b0, 4'd0, 16'h0004);
    rd(1'b0, 4'd0, 16'h0000, "w1c_match");
    check("irq_after_w1c", {63'h0, irq_a}, 64'h0);
    wr(1'b0, 4'd1, 16'h0401);
    repeat (31) @(negedge clk);
    wr(1'b0, 4'd0, 16'h0004);
    check("cnt_at_collide", cnt_a, 64'h20);
    rd(1'b0, 4'd0, 16'h8004, "set_beats_clear");

    // Host and hardware snapshot in the same cycle, then hardware alone
    @(negedge clk);
    snap_exp = cnt_a;
    addr = 4'd3; wn = 1'b0; cs_a = 1'b1; trig_a = 1'b1;
    @(posedge clk); #1;
    cs_a = 1'b0; wn = 1'b1; trig_a = 1'b0;
    rd(1'b0, 4'd4, snap_exp[15:0],  "dual_snap_w0");
    rd(1'b0, 4'd5, snap_exp[31:16], "dual_snap_w1");
    repeat (5) @(negedge clk);
    @(negedge clk);
    snap_exp = cnt_a;
    trig_a = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
    rd(1'b0, 4'd4, snap_exp[15:0], "hw_snap_w0");

    // 16-bit wrap and overflow interrupt
    wr(1'b1, 4'd1, 16'h0103);
    found = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (cnt_b == 16'hFFFE) begin found = 1'b1; break; end
    end
    check("ovf_reach_fffe", {63'h0, found}, 64'h1);
    check("irq16_pre", {63'h0, irq_b}, 64'h0);
    @(negedge clk);
    check("cnt16_ffff", {48'h0, cnt_b}, 64'hFFFF);
    @(negedge clk);
    check("cnt16_wrap", {48'h0, cnt_b}, 64'h0);
    check("irq16_wrap_cycle", {63'h0, irq_b}, 64'h0);
    @(negedge clk);
    check("irq16_ovf", {63'h0, irq_b}, 64'h1);
    rd(1'b1, 4'd0, 16'h8007, "status16_ovf_match");
    wr(1'b1, 4'd0, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    check("irq16_cleared", {63'h0, irq_b}, 64'h0);
    rd(1'b1, 4'd0, 16'h8006, "status16_after_clr");

    // Asynchronous reset mid-count
    check("irq_before_rst", {63'h0, irq_a}, 64'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt_a, 64'h0);
    check("async_rst_irq", {63'h0, irq_a}, 64'h0);
    check("async_rst_cnt16", {48'h0, cnt_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(1'b0, 4'd1, 16'h0000, "ctrl_after_rst");
    rd(1'b0, 4'd14, 16'hFFFF, "cmp_after_rst");
    rd(1'b0, 4'd0, 16'h0000, "status_after_rst");

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
